// File: rtl/bus_pkg.sv
// Shared definitions for the 8-bit memory-mapped peripheral bus.
// Bus masters reuse the state encodings below for debug visibility.
package bus_pkg;

  localparam int unsigned BusAw = 8;
  localparam int unsigned BusDw = 8;

  // Address parked on the bus while idle; no peripheral decodes it.
  localparam logic [BusAw-1:0] IdleAddr = 8'hFF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWr   = 2'd1,
    StRd   = 2'd2,
    StRsp  = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bus_initiator_if.sv
// Command/response handshake plus registered bus address/write-enable of the bus initiator.
// The bidirectional data lines stay a plain port on the initiator.
interface bus_initiator_if;
  import bus_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [BusAw-1:0] cmd_addr;
  logic [BusDw-1:0] cmd_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [BusDw-1:0] rsp_rdata;
  logic             busy;
  logic [BusAw-1:0] bus_addr;
  logic             bus_we;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, busy, bus_addr, bus_we
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, busy, bus_addr, bus_we
  );

endinterface

// File: rtl/bus_initiator.sv
// Bus initiator: runs one accepted read/write command at a time on the shared 8-bit bus and
// returns read data on a valid/ready response port.
module bus_initiator
  import bus_pkg::*;
#(
  parameter logic [BusAw-1:0] IdleAddress = IdleAddr,
  parameter int unsigned      ReadLatency = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bus_initiator_if.master      bus,
  inout  wire  [BusDw-1:0]     bus_data
);

  localparam logic [3:0] RdLast = 4'(ReadLatency - 1);

  bus_state_e       state_q, state_d;
  logic [BusAw-1:0] addr_q, addr_d;
  logic [BusDw-1:0] wdata_q, wdata_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BusDw-1:0] rdata_q, rdata_d;
  logic [BusAw-1:0] bus_addr_q, bus_addr_d;
  logic             bus_we_q, bus_we_d;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    bus.cmd_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          cnt_d   = 4'd0;
          state_d = bus.cmd_we ? StWr : StRd;
        end
      end
      StWr: state_d = StIdle;
      StRd: begin
        // Peripheral drive is registered, so data is only valid in the last RD cycle.
        if (cnt_q == RdLast) begin
          rdata_d = bus_data;
          state_d = StRsp;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRsp: if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Bus outputs are registered from the next state so they change with the state itself.
    bus_addr_d = ((state_d == StWr) || (state_d == StRd)) ? addr_d : IdleAddress;
    bus_we_d   = (state_d == StWr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= IdleAddress;
      wdata_q    <= '0;
      cnt_q      <= 4'd0;
      rdata_q    <= '0;
      bus_addr_q <= IdleAddress;
      bus_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      bus_addr_q <= bus_addr_d;
      bus_we_q   <= bus_we_d;
    end
  end

  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.rsp_valid = (state_q == StRsp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.busy      = (state_q != StIdle);

  // RSP follows RD, so this block never drives in the turnaround cycle.
  assign bus_data = (state_q == StWr) ? wdata_q : {BusDw{1'bz}};

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: two builds (read latency 2 and 4), each with a register
// responder at 0xC0 and a keeper that drives 0x00 whenever neither side should own the bus.
module tb_bus_initiator;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_initiator_if ifa ();
  bus_initiator_if ifb ();
  wire [7:0] bus_data_a;
  wire [7:0] bus_data_b;

  bus_initiator #(.ReadLatency(2)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifa),
    .bus_data (bus_data_a)
  );

  bus_initiator #(.ReadLatency(4)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifb),
    .bus_data (bus_data_b)
  );

  // Responder A: register at 0xC0, read drive enabled one edge after the address is seen.
  logic [7:0] reg_a = 8'h00;
  logic       sel_a;
  always @(posedge clk)
    if (ifa.bus_we && ifa.bus_addr == 8'hC0) reg_a <= bus_data_a;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) sel_a <= 1'b0;
    else        sel_a <= !ifa.bus_we && (ifa.bus_addr == 8'hC0);
  assign bus_data_a = sel_a ? reg_a : (!ifa.bus_we ? 8'h00 : 8'hzz);

  // Responder B: same register, read drive enabled three edges after the address is seen.
  logic [7:0] reg_b = 8'h00;
  logic [2:0] sel_b;
  always @(posedge clk)
    if (ifb.bus_we && ifb.bus_addr == 8'hC0) reg_b <= bus_data_b;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) sel_b <= 3'b000;
    else        sel_b <= {sel_b[1:0], !ifb.bus_we && (ifb.bus_addr == 8'hC0)};
  assign bus_data_b = sel_b[2] ? reg_b : (!ifb.bus_we ? 8'h00 : 8'hzz);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Whenever the initiator is not writing, the bus must show exactly the responder or keeper.
  task automatic bus_mon();
    if (ifa.bus_we) chk("a_no_contention_in_wr", {31'd0, sel_a}, 32'd0);
    else            chk("a_bus_owner", bus_data_a, sel_a ? reg_a : 8'h00);
    if (ifb.bus_we) chk("b_no_contention_in_wr", {31'd0, sel_b[2]}, 32'd0);
    else            chk("b_bus_owner", bus_data_b, sel_b[2] ? reg_b : 8'h00);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus_mon();
  endtask

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  // One full command on DUT A, presented in IDLE; read responses consumed immediately.
  task automatic run_cmd(input vec_t v);
    ifa.cmd_valid = 1'b1;
    ifa.cmd_we    = v.we;
    ifa.cmd_addr  = v.addr;
    ifa.cmd_wdata = v.we ? v.wdata : 8'h42;
    ifa.rsp_ready = 1'b1;
    chk("cmd_ready_idle", {31'd0, ifa.cmd_ready}, 32'd1);
    step();
    ifa.cmd_valid = 1'b0;
    if (v.we) begin
      chk("wr_bus_we", {31'd0, ifa.bus_we}, 32'd1);
      chk("wr_bus_addr", ifa.bus_addr, v.addr);
      chk("wr_bus_data", bus_data_a, v.wdata);
      chk("wr_cmd_ready", {31'd0, ifa.cmd_ready}, 32'd0);
      chk("wr_no_rsp", {31'd0, ifa.rsp_valid}, 32'd0);
      step();
      chk("wr_end_we", {31'd0, ifa.bus_we}, 32'd0);
      chk("wr_end_addr", ifa.bus_addr, 8'hFF);
      chk("wr_end_no_rsp", {31'd0, ifa.rsp_valid}, 32'd0);
      if (v.addr == 8'hC0) chk("wr_model_reg", reg_a, v.wdata);
    end else begin
      for (int c = 0; c < 2; c++) begin
        chk("rd_bus_addr", ifa.bus_addr, v.addr);
        chk("rd_bus_we", {31'd0, ifa.bus_we}, 32'd0);
        chk("rd_no_rsp_yet", {31'd0, ifa.rsp_valid}, 32'd0);
        step();
      end
      chk("rd_rsp_valid", {31'd0, ifa.rsp_valid}, 32'd1);
      chk("rd_rdata", ifa.rsp_rdata, v.exp_rdata);
      chk("rsp_bus_addr", ifa.bus_addr, 8'hFF);
      step();
      chk("rd_rsp_done", {31'd0, ifa.rsp_valid}, 32'd0);
    end
  endtask

  vec_t vecs[7];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{we: 1'b1, addr: 8'hC0, wdata: 8'hA5, exp_rdata: 8'h00};
    vecs[1] = '{we: 1'b0, addr: 8'hC0, wdata: 8'h00, exp_rdata: 8'hA5};
    vecs[2] = '{we: 1'b1, addr: 8'hC0, wdata: 8'h3C, exp_rdata: 8'h00};
    vecs[3] = '{we: 1'b0, addr: 8'hC0, wdata: 8'h00, exp_rdata: 8'h3C};
    vecs[4] = '{we: 1'b1, addr: 8'hFF, wdata: 8'h11, exp_rdata: 8'h00};
    vecs[5] = '{we: 1'b1, addr: 8'h00, wdata: 8'h22, exp_rdata: 8'h00};
    vecs[6] = '{we: 1'b0, addr: 8'hC0, wdata: 8'h00, exp_rdata: 8'h3C};

    ifa.cmd_valid = 1'b0; ifa.cmd_we = 1'b0; ifa.cmd_addr = 8'h00;
    ifa.cmd_wdata = 8'h00; ifa.rsp_ready = 1'b0;
    ifb.cmd_valid = 1'b0; ifb.cmd_we = 1'b0; ifb.cmd_addr = 8'h00;
    ifb.cmd_wdata = 8'h00; ifb.rsp_ready = 1'b0;

    step();
    step();
    chk("rst_bus_addr", ifa.bus_addr, 8'hFF);
    chk("rst_bus_we", {31'd0, ifa.bus_we}, 32'd0);
    chk("rst_rsp_valid", {31'd0, ifa.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", ifa.rsp_rdata, 8'h00);
    chk("rst_busy", {31'd0, ifa.busy}, 32'd0);
    chk("rst_cmd_ready", {31'd0, ifa.cmd_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // Write, read back, read immediately followed by write, boundary addresses.
    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // Response back-pressure with a write pending behind it.
    ifa.cmd_valid = 1'b1; ifa.cmd_we = 1'b0; ifa.cmd_addr = 8'hC0;
    ifa.cmd_wdata = 8'h42; ifa.rsp_ready = 1'b0;
    step();
    ifa.cmd_we = 1'b1; ifa.cmd_addr = 8'h10; ifa.cmd_wdata = 8'h5A;
    step();
    step();
    chk("bp_rsp_valid", {31'd0, ifa.rsp_valid}, 32'd1);
    chk("bp_rdata", ifa.rsp_rdata, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", {31'd0, ifa.rsp_valid}, 32'd1);
      chk("bp_hold_rdata", ifa.rsp_rdata, 8'h3C);
      chk("bp_cmd_ready", {31'd0, ifa.cmd_ready}, 32'd0);
    end
    ifa.rsp_ready = 1'b1;
    step();
    chk("bp_released", {31'd0, ifa.rsp_valid}, 32'd0);
    chk("bp_next_ready", {31'd0, ifa.cmd_ready}, 32'd1);
    step();
    ifa.cmd_valid = 1'b0;
    chk("bp_next_wr_we", {31'd0, ifa.bus_we}, 32'd1);
    chk("bp_next_wr_addr", ifa.bus_addr, 8'h10);
    chk("bp_next_wr_data", bus_data_a, 8'h5A);
    step();

    // Reset asserted in the first RD cycle.
    ifa.cmd_valid = 1'b1; ifa.cmd_we = 1'b0; ifa.cmd_addr = 8'hC0; ifa.cmd_wdata = 8'h42;
    step();
    ifa.cmd_valid = 1'b0;
    chk("pre_rst_rd_addr", ifa.bus_addr, 8'hC0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bus_addr", ifa.bus_addr, 8'hFF);
    chk("mid_rst_bus_we", {31'd0, ifa.bus_we}, 32'd0);
    chk("mid_rst_bus_data", bus_data_a, 8'h00);
    chk("mid_rst_rsp_valid", {31'd0, ifa.rsp_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, ifa.busy}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_cmd_ready", {31'd0, ifa.cmd_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, ifa.busy}, 32'd0);
    chk("post_rst_no_rsp", {31'd0, ifa.rsp_valid}, 32'd0);
    run_cmd(vecs[6]);

    // Read latency 4 against a three-edge responder drive delay.
    ifb.cmd_valid = 1'b1; ifb.cmd_we = 1'b1; ifb.cmd_addr = 8'hC0;
    ifb.cmd_wdata = 8'h96; ifb.rsp_ready = 1'b1;
    step();
    ifb.cmd_valid = 1'b0;
    chk("b_wr_data", bus_data_b, 8'h96);
    step();
    chk("b_model_reg", reg_b, 8'h96);
    ifb.cmd_valid = 1'b1; ifb.cmd_we = 1'b0; ifb.cmd_wdata = 8'h42;
    step();
    ifb.cmd_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("b_rd_no_rsp_yet", {31'd0, ifb.rsp_valid}, 32'd0);
      chk("b_rd_addr", ifb.bus_addr, 8'hC0);
      step();
    end
    chk("b_rsp_valid", {31'd0, ifb.rsp_valid}, 32'd1);
    chk("b_rdata", ifb.rsp_rdata, 8'h96);
    step();
    chk("b_rsp_done", {31'd0, ifb.rsp_valid}, 32'd0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
